// File: rtl/herring_vga_scanout.sv
// herring_vga_scanout: VGA timing generator that pulls pixels from a valid/ready stream; HERRING_TEST_PATTERN_EN adds a colour-bar test mode
module herring_vga_scanout #(
   parameter int H_ACTIVE   = 800,
   parameter int H_FP       = 40,
   parameter int H_SYNC     = 128,
   parameter int H_BP       = 88,
   parameter int V_ACTIVE   = 600,
   parameter int V_FP       = 1,
   parameter int V_SYNC     = 4,
   parameter int V_BP       = 23,
   parameter int HSYNC_POL  = 1,
   parameter int VSYNC_POL  = 1,
   parameter int COLOR_BITS = 1
) (
   input  logic                    PIXEL_CLOCK,
   input  logic                    RESET,
   input  logic [3*COLOR_BITS-1:0] PIX_DATA,
   input  logic                    PIX_VALID,
   output logic                    PIX_READY,
   output logic                    FRAME_START,
   output logic [COLOR_BITS-1:0]   VGA_RED,
   output logic [COLOR_BITS-1:0]   VGA_GREEN,
   output logic [COLOR_BITS-1:0]   VGA_BLUE,
   output logic                    VGA_HSYNC,
   output logic                    VGA_VSYNC,
   output logic                    UNDERFLOW,
`ifdef HERRING_TEST_PATTERN_EN
   input  logic                    TEST_MODE,
`endif
   input  logic                    UNDERFLOW_CLR
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic HP = (HSYNC_POL != 0);
   localparam logic VP = (VSYNC_POL != 0);

   logic [HW-1:0]           h_q, h_d;
   logic [VW-1:0]           v_q, v_d;
   logic [3*COLOR_BITS-1:0] rgb_q, rgb_d, pat;
   logic                    hs_q, hs_d, vs_q, vs_d, uf_q, uf_d;
   logic                    active, transfer, tm;

`ifdef HERRING_TEST_PATTERN_EN
   localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);
   logic [HW-1:0] bar;
   assign tm  = TEST_MODE;
   assign bar = h_q / BAR_W;
   assign pat = {{COLOR_BITS{bar[2]}}, {COLOR_BITS{bar[1]}}, {COLOR_BITS{bar[0]}}};
`else
   assign tm  = 1'b0;
   assign pat = '0;
`endif

   // next raster position, stream handshake and next values of the registered outputs
   always_comb begin
      h_d         = (h_q == H_LAST) ? '0 : h_q + 1'b1;
      v_d         = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 1'b1;
      active      = (h_q < H_ACT) && (v_q < V_ACT);
      PIX_READY   = active && !RESET && !tm;
      FRAME_START = (h_q == '0) && (v_q == '0) && !RESET;
      transfer    = PIX_READY && PIX_VALID;
      rgb_d       = transfer ? PIX_DATA : (active && tm) ? pat : '0;
      hs_d        = (h_q >= H_SS && h_q < H_SE) ? HP : ~HP;
      vs_d        = (v_q >= V_SS && v_q < V_SE) ? VP : ~VP;
      uf_d        = (active && !PIX_VALID && !tm) ? 1'b1 : UNDERFLOW_CLR ? 1'b0 : uf_q;
   end

   // raster counters; reset restarts the frame at pixel (0,0)
   always_ff @(posedge PIXEL_CLOCK) begin
      if (RESET) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // colour, syncs and sticky underflow, all one cycle behind the counters
   always_ff @(posedge PIXEL_CLOCK) begin
      if (RESET) begin
         rgb_q <= '0;
         hs_q  <= ~HP;
         vs_q  <= ~VP;
         uf_q  <= 1'b0;
      end else begin
         rgb_q <= rgb_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         uf_q  <= uf_d;
      end
   end

   assign VGA_RED   = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
   assign VGA_GREEN = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
   assign VGA_BLUE  = rgb_q[COLOR_BITS-1:0];
   assign VGA_HSYNC = hs_q;
   assign VGA_VSYNC = vs_q;
   assign UNDERFLOW = uf_q;
endmodule
